// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  // Index register width; a one-nibble counter still needs one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/adder_4b.sv
// Combinational 4-bit ripple-carry adder; the single arithmetic unit of the serial adder.
module adder_4b
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic ripple_c;

  always_comb begin
    sum      = '0;
    ripple_c = cin;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ ripple_c;
      ripple_c = (a[i] & b[i]) | (ripple_c & (a[i] ^ b[i]));
    end
    cout = ripple_c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that processes one nibble per cycle through a single adder_4b.
// Define NSA_SUB_EN to add the sub port (A + ~B + 1 when sub is set at capture).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  nsa_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
`ifdef NSA_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic [NIBBLE_W-1:0] add_a_c;
  logic [NIBBLE_W-1:0] add_b_c;
  logic [NIBBLE_W-1:0] add_sum_c;
  logic                add_cout_c;

  // Select the current operand nibbles; subtraction inverts B on the fly.
  always_comb begin
    add_a_c = '0;
    add_b_c = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        add_a_c = a_q[i*NIBBLE_W +: NIBBLE_W];
        add_b_c = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
`ifdef NSA_SUB_EN
    if (sub_q) begin
      add_b_c = ~add_b_c;
    end
`endif
  end

  adder_4b u_adder (
    .a    (add_a_c),
    .b    (add_b_c),
    .cin  (carry_q),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NSA_SUB_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          state_d = RUN;
`ifdef NSA_SUB_EN
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
`else
          carry_d = cin;
`endif
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = add_sum_c;
          end
        end
        carry_d = add_cout_c;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = add_cout_c;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // in_ready resets low and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef NSA_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef NSA_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder against an arithmetic reference.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NSA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NSA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: {cout, sum} of A + B + cin, or A + ~B + 1.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic s);
    longint unsigned opb;
    longint unsigned tot;
    opb = s ? ((64'd1 << WIDTH) - 64'd1 - 64'(y)) : 64'(y);
    tot = 64'(x) + opb + (s ? 64'd1 : 64'(ci));
    return tot[WIDTH:0];
  endfunction

  task automatic scramble_inputs();
    a   = WIDTH'($urandom);
    b   = WIDTH'($urandom);
    cin = 1'($urandom);
`ifdef NSA_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  // One full transaction; operands are scrambled while busy to show they are ignored.
  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xc, input logic xs, input int hold);
    logic [WIDTH:0] r;
    int lat;
    int waitc;
    r = ref_add(xa, xb, xc, xs);
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_idle", 32'(in_ready), 32'd1);
    a        = xa;
    b        = xb;
    cin      = xc;
`ifdef NSA_SUB_EN
    sub      = xs;
`endif
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    scramble_inputs();
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      if (lat == 0) check("ready_run", 32'(in_ready), 32'd0);
      scramble_inputs();
      lat++;
    end
    check("latency", 32'(lat), 32'(NIBBLES));
    check("sum", 32'(sum), 32'(r[WIDTH-1:0]));
    check("cout", 32'(cout), 32'(r[WIDTH]));
    for (int h = 0; h < hold; h++) begin
      scramble_inputs();
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(r[WIDTH-1:0]));
      check("hold_cout", 32'(cout), 32'(r[WIDTH]));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("drop_valid", 32'(out_valid), 32'd0);
    check("back_ready", 32'(in_ready), 32'd1);
    check("retain_sum", 32'(sum), 32'(r[WIDTH-1:0]));
    check("retain_cout", 32'(cout), 32'(r[WIDTH]));
  endtask

  initial begin
    logic s_rand;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef NSA_SUB_EN
    sub       = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'hA5C3, 16'h7E19, 1'b1, 1'b0, 5);
`ifdef NSA_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
`ifdef NSA_SUB_EN
      s_rand = 1'($urandom);
`else
      s_rand = 1'b0;
`endif
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s_rand, $urandom_range(0, 3));
    end

    // Abort mid-operation with reset at idx==2.
    @(negedge clk);
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end

    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
